// File: rtl/stage_ex_mc_if.sv
// Execute-stage bundle: decoded instruction from ID and the EX results.
// The stage is the slave; the ID/pipeline side is the master.
interface stage_ex_mc_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic [31:0]      id_inst;
    logic [3:0]       id_op;
    logic [WIDTH-1:0] id_opa;
    logic [WIDTH-1:0] id_opb;
    logic             id_memWE;
    logic [WIDTH-1:0] id_memData;
    logic             id_rfWE;
    logic [4:0]       id_rfDst;
    logic [1:0]       id_rfSrc;
    logic [2:0]       id_branchType;
    logic [31:0]      id_branchDst;

    logic [31:0]      ex_inst;
    logic             ex_memWE;
    logic [WIDTH-1:0] ex_memData;
    logic             ex_rfWE;
    logic [4:0]       ex_rfDst;
    logic [1:0]       ex_rfSrc;
    logic [31:0]      ex_branchDst;
    logic [WIDTH-1:0] ex_opResult;
    logic             ex_branchPermit;
    logic             ex_stall;
    logic [WIDTH-1:0] ex_hi;
    logic [WIDTH-1:0] ex_lo;

    modport master (
        output flush, id_inst, id_op, id_opa, id_opb, id_memWE,
               id_memData, id_rfWE, id_rfDst, id_rfSrc,
               id_branchType, id_branchDst,
        input  ex_inst, ex_memWE, ex_memData, ex_rfWE, ex_rfDst,
               ex_rfSrc, ex_branchDst, ex_opResult,
               ex_branchPermit, ex_stall, ex_hi, ex_lo
    );

    modport slave (
        input  flush, id_inst, id_op, id_opa, id_opb, id_memWE,
               id_memData, id_rfWE, id_rfDst, id_rfSrc,
               id_branchType, id_branchDst,
        output ex_inst, ex_memWE, ex_memData, ex_rfWE, ex_rfDst,
               ex_rfSrc, ex_branchDst, ex_opResult,
               ex_branchPermit, ex_stall, ex_hi, ex_lo
    );
endinterface

// File: rtl/stage_ex_mc.sv
// MIPS execute stage: ID/EX register, ALU, branch resolve and an
// iterative unsigned multiply/divide unit with HI/LO.
module stage_ex_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    stage_ex_mc_if.slave   io
);
    localparam logic [3:0] OP_MULTU = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef struct packed {
        logic [31:0]      inst;
        logic [3:0]       op;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic             memWE;
        logic [WIDTH-1:0] memData;
        logic             rfWE;
        logic [4:0]       rfDst;
        logic [1:0]       rfSrc;
        logic [2:0]       branchType;
        logic [31:0]      branchDst;
    } ex_t;

    ex_t              ex_q, ex_d;
    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             stall;
    logic             start;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshl;
    logic [WIDTH-1:0] ddif;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0] res;
    logic [SHW-1:0]   sh;
    logic             zero;
    logic             permit;

    assign stall = (state_q == RUN);
    assign start = !io.flush && !stall &&
                   (io.id_op == OP_MULTU || io.id_op == OP_DIVU);

    // acc holds {hi, lo} of the product, or {remainder, dividend/quotient}
    always_comb begin
        msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : '0);
        dshl = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ddif = WIDTH'(dshl - {1'b0, opnd_q});
        step = '0;
        if (ex_q.op == OP_DIVU) begin
            if (dshl >= {1'b0, opnd_q})
                step = {ddif, acc_q[WIDTH-2:0], 1'b1};
            else
                step = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            step = {msum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        ex_d    = ex_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (io.flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.inst       = io.id_inst;
            ex_d.op         = io.id_op;
            ex_d.opa        = io.id_opa;
            ex_d.opb        = io.id_opb;
            ex_d.memWE      = io.id_memWE;
            ex_d.memData    = io.id_memData;
            ex_d.rfWE       = io.id_rfWE;
            ex_d.rfDst      = io.id_rfDst;
            ex_d.rfSrc      = io.id_rfSrc;
            ex_d.branchType = io.id_branchType;
            ex_d.branchDst  = io.id_branchDst;
        end
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    if (io.id_op == OP_DIVU) begin
                        acc_d  = {{WIDTH{1'b0}}, io.id_opa};
                        opnd_d = io.id_opb;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, io.id_opb};
                        opnd_d = io.id_opa;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = step[2*WIDTH-1:WIDTH];
                    lo_d    = step[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (io.flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign sh = ex_q.opa[SHW-1:0];

    always_comb begin
        res = '0;
        case (ex_q.op)
            4'h0: res = ex_q.opa + ex_q.opb;
            4'h1: res = ex_q.opa - ex_q.opb;
            4'h2: res = ex_q.opa & ex_q.opb;
            4'h3: res = ex_q.opa | ex_q.opb;
            4'h4: res = ex_q.opb << sh;
            4'h5: res = ex_q.opb >> sh;
            4'h6: res = $signed(ex_q.opb) >>> sh;
            4'h7: res = ex_q.opa ^ ex_q.opb;
            4'h8: res = ~(ex_q.opa | ex_q.opb);
            4'h9: res = WIDTH'($signed(ex_q.opa) < $signed(ex_q.opb));
            4'hA: res = WIDTH'(ex_q.opa < ex_q.opb);
            4'hD: res = hi_q;
            4'hE: res = lo_q;
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

    always_comb begin
        permit = 1'b0;
        case (ex_q.branchType)
            3'd1: permit = zero;
            3'd2: permit = !zero;
            3'd3: permit = $signed(ex_q.opa) <= 0;
            3'd4: permit = $signed(ex_q.opa) > 0;
            3'd5: permit = $signed(ex_q.opa) < 0;
            3'd6: permit = $signed(ex_q.opa) >= 0;
            3'd7: permit = 1'b1;
            default: permit = 1'b0;
        endcase
    end

    assign io.ex_inst         = ex_q.inst;
    assign io.ex_memWE        = ex_q.memWE;
    assign io.ex_memData      = ex_q.memData;
    assign io.ex_rfWE         = ex_q.rfWE;
    assign io.ex_rfDst        = ex_q.rfDst;
    assign io.ex_rfSrc        = ex_q.rfSrc;
    assign io.ex_branchDst    = ex_q.branchDst;
    assign io.ex_opResult     = res;
    assign io.ex_branchPermit = permit;
    assign io.ex_stall        = stall;
    assign io.ex_hi           = hi_q;
    assign io.ex_lo           = lo_q;
endmodule

// File: tb/tb_stage_ex_mc.sv
// Directed bench for stage_ex_mc: ALU, branches, multu/divu latency,
// HI/LO results, flush abort and asynchronous reset.
module tb_stage_ex_mc;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   n;

    stage_ex_mc_if #(.WIDTH(32)) bus ();

    stage_ex_mc #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        bus.id_inst       = '0;
        bus.id_op         = 4'h0;
        bus.id_opa        = '0;
        bus.id_opb        = '0;
        bus.id_memWE      = 1'b0;
        bus.id_memData    = '0;
        bus.id_rfWE       = 1'b0;
        bus.id_rfDst      = '0;
        bus.id_rfSrc      = '0;
        bus.id_branchType = '0;
        bus.id_branchDst  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one instruction, clock it into EX, then drive a nop
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] bt,
                         input logic [31:0] inst);
        bus.id_inst       = inst;
        bus.id_op         = op;
        bus.id_opa        = a;
        bus.id_opb        = b;
        bus.id_memWE      = 1'b1;
        bus.id_memData    = a ^ b;
        bus.id_rfWE       = 1'b1;
        bus.id_rfDst      = 5'd7;
        bus.id_rfSrc      = 2'd2;
        bus.id_branchType = bt;
        bus.id_branchDst  = 32'h0000_0100;
        tick();
        idle_in();
    endtask

    task automatic wait_stall(output int cyc);
        cyc = 0;
        while (bus.ex_stall && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.flush = 1'b0;
        idle_in();
        #2;
        chk("rst_res", bus.ex_opResult, 0);
        chk("rst_stall", bus.ex_stall, 0);
        chk("rst_hi", bus.ex_hi, 0);
        chk("rst_lo", bus.ex_lo, 0);
        @(negedge clk);
        rst = 1'b1;

        issue(4'h0, 32'd5, 32'd7, 3'd0, 32'h1111_0001);
        chk("add", bus.ex_opResult, 32'd12);
        chk("add_inst", bus.ex_inst, 32'h1111_0001);
        chk("add_mdata", bus.ex_memData, 32'd2);
        chk("add_dst", bus.ex_rfDst, 5'd7);
        chk("add_bdst", bus.ex_branchDst, 32'h100);
        issue(4'h6, 32'd4, 32'h8000_0000, 3'd0, 32'h2);
        chk("sra", bus.ex_opResult, 32'hF800_0000);
        issue(4'h4, 32'h24, 32'h1, 3'd0, 32'h3);
        chk("sll", bus.ex_opResult, 32'h10);
        issue(4'h5, 32'd4, 32'h8000_0000, 3'd0, 32'h4);
        chk("srl", bus.ex_opResult, 32'h0800_0000);
        issue(4'h9, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'h5);
        chk("slt", bus.ex_opResult, 32'd1);
        issue(4'hA, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'h6);
        chk("sltu", bus.ex_opResult, 32'd0);
        issue(4'h8, 32'h0F0F_0000, 32'h0000_00F0, 3'd0, 32'h7);
        chk("nor", bus.ex_opResult, 32'hF0F0_FF0F);
        issue(4'h7, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd0, 32'h8);
        chk("xor", bus.ex_opResult, 32'hF0F0_F0F0);

        issue(4'h1, 32'd3, 32'd3, 3'd1, 32'h9);
        chk("beq", bus.ex_branchPermit, 1);
        issue(4'h0, 32'hFFFF_FFFF, 32'd0, 3'd5, 32'hA);
        chk("bltz", bus.ex_branchPermit, 1);
        issue(4'h0, 32'hFFFF_FFFF, 32'd0, 3'd6, 32'hB);
        chk("bgez", bus.ex_branchPermit, 0);
        issue(4'h1, 32'd3, 32'd3, 3'd0, 32'hC);
        chk("bnever", bus.ex_branchPermit, 0);
        issue(4'h0, 32'd0, 32'd0, 3'd3, 32'hD);
        chk("blez", bus.ex_branchPermit, 1);

        issue(4'hB, 32'hFFFF_FFFF, 32'd2, 3'd0, 32'hE);
        chk("mul_stall", bus.ex_stall, 1);
        tick();
        chk("mul_hold", bus.ex_inst, 32'hE);
        wait_stall(n);
        chk("mul_cyc", n + 1, 32);
        chk("mul_hi", bus.ex_hi, 32'd1);
        chk("mul_lo", bus.ex_lo, 32'hFFFF_FFFE);
        issue(4'hE, 32'd0, 32'd0, 3'd0, 32'hF);
        chk("mflo", bus.ex_opResult, 32'hFFFF_FFFE);
        chk("mflo_stall", bus.ex_stall, 0);

        issue(4'hC, 32'd100, 32'd7, 3'd0, 32'h10);
        wait_stall(n);
        chk("div1_cyc", n, 32);
        chk("div1_lo", bus.ex_lo, 32'd14);
        chk("div1_hi", bus.ex_hi, 32'd2);
        issue(4'hC, 32'd100, 32'd0, 3'd0, 32'h11);
        chk("div2_stall", bus.ex_stall, 1);
        wait_stall(n);
        chk("div2_cyc", n, 32);
        chk("div0_lo", bus.ex_lo, 32'hFFFF_FFFF);
        chk("div0_hi", bus.ex_hi, 32'd100);
        issue(4'hD, 32'd0, 32'd0, 3'd0, 32'h12);
        chk("mfhi", bus.ex_opResult, 32'd100);

        issue(4'hB, 32'd3, 32'd5, 3'd0, 32'h13);
        repeat (9) tick();
        chk("fl_pre", bus.ex_stall, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_stall", bus.ex_stall, 0);
        chk("fl_hi", bus.ex_hi, 32'd100);
        chk("fl_lo", bus.ex_lo, 32'hFFFF_FFFF);
        chk("fl_inst", bus.ex_inst, 0);
        chk("fl_dst", bus.ex_rfDst, 0);
        tick();
        chk("fl_idle", bus.ex_stall, 0);

        issue(4'hB, 32'd3, 32'd5, 3'd7, 32'h14);
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_stall", bus.ex_stall, 0);
        chk("ar_inst", bus.ex_inst, 0);
        chk("ar_hi", bus.ex_hi, 0);
        chk("ar_lo", bus.ex_lo, 0);
        chk("ar_res", bus.ex_opResult, 0);
        chk("ar_br", bus.ex_branchPermit, 0);
        @(negedge clk);
        rst = 1'b1;
        issue(4'h0, 32'd1, 32'd1, 3'd0, 32'h15);
        chk("post_rst_add", bus.ex_opResult, 32'd2);
        chk("post_rst_stall", bus.ex_stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
